// File: rtl/pc_sequencer_pkg.sv
// Shared sequencer/decoder definitions: FSM state encoding, opcode values and
// the opcode classification used to steer EXEC.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_SHIFT = 4'b0000;
    localparam logic [3:0] OP_BEQ   = 4'b0001;
    localparam logic [3:0] OP_BNE   = 4'b0010;
    localparam logic [3:0] OP_BLT   = 4'b0011;
    localparam logic [3:0] OP_LD    = 4'b0100;
    localparam logic [3:0] OP_ST    = 4'b0101;
    localparam logic [3:0] OP_PUSH  = 4'b0110;
    localparam logic [3:0] OP_POP   = 4'b0111;
    localparam logic [3:0] OP_DONE  = 4'b1111;

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_HALT   = 2'd3
    } op_class_t;

    // Anything unrecognised (including X) lands on the plain ALU path.
    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        cls = CLS_OTHER;
        case (op)
            OP_BEQ, OP_BNE, OP_BLT: cls = CLS_BRANCH;
            OP_LD, OP_ST:           cls = CLS_MEM;
            OP_DONE:                cls = CLS_HALT;
            default:                cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bundle between the sequencer (slave) and the core/fetch logic (master).
interface pc_sequencer_if #(
    parameter int PCW = 10
);
    logic           start;
    logic [3:0]     instr_op;
    logic           branch_taken;
    logic [PCW-1:0] branch_target;
    logic [PCW-1:0] pc;
    logic           fetch_en;
    logic           reg_wr_en;
    logic           mem_wr_en;
    logic           busy;
    logic           done;
    logic [15:0]    retired;

    modport slave (
        input  start, instr_op, branch_taken, branch_target,
        output pc, fetch_en, reg_wr_en, mem_wr_en, busy, done, retired
    );

    modport master (
        output start, instr_op, branch_taken, branch_target,
        input  pc, fetch_en, reg_wr_en, mem_wr_en, busy, done, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, steps FETCH/EXEC/MEM_WAIT,
// gates write strobes to one pulse per retired instruction and counts retirements.
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int PCW     = 10,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    pc_sequencer_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    seq_state_t     state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           done_q, done_d;
    logic [15:0]    retired_q, retired_d;
    logic [3:0]     wait_q, wait_d;

    logic           fetch_en;
    logic           reg_wr_en;
    logic           mem_wr_en;
    logic           busy;
    logic           retire;
    logic [PCW-1:0] pc_inc;
    op_class_t      cls;

    assign pc_inc = pc_q + PCW'(1);
    assign cls    = op_class(bus.instr_op);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        done_d    = done_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        fetch_en  = 1'b0;
        reg_wr_en = 1'b0;
        mem_wr_en = 1'b0;
        busy      = 1'b0;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = ST_FETCH;
                end
            end

            ST_FETCH: begin
                fetch_en = 1'b1;
                busy     = 1'b1;
                state_d  = ST_EXEC;
            end

            ST_EXEC: begin
                busy = 1'b1;
                case (cls)
                    CLS_BRANCH: begin
                        pc_d    = bus.branch_taken ? bus.branch_target : pc_inc;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_MEM: begin
                        wait_d  = WAIT_INIT;
                        state_d = ST_MEM_WAIT;
                    end
                    CLS_HALT: begin
                        done_d  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end
                    default: begin
                        reg_wr_en = 1'b1;
                        pc_d      = pc_inc;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end

            // The strobe fires on the last wait cycle so the memory has had
            // MEM_LAT cycles to settle before the result is committed.
            ST_MEM_WAIT: begin
                busy = 1'b1;
                if (wait_q == 4'd0) begin
                    if (bus.instr_op == OP_ST) begin
                        mem_wr_en = 1'b1;
                    end else begin
                        reg_wr_en = 1'b1;
                    end
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            ST_HALT: begin
                if (bus.start) begin
                    done_d    = 1'b0;
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            done_q    <= 1'b0;
            retired_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.done      = done_q;
    assign bus.retired   = retired_q;
    assign bus.fetch_en  = fetch_en;
    assign bus.reg_wr_en = reg_wr_en;
    assign bus.mem_wr_en = mem_wr_en;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (PCW=10/MEM_LAT=1 and PCW=4/MEM_LAT=3)
// checked each cycle against an instruction-level trace model plus literal pins.
module tb_pc_sequencer;
    import proc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;

    logic [3:0] prog [16];
    logic       btk  [16];
    logic [9:0] btg  [16];

    pc_sequencer_if #(.PCW(10)) if0 ();
    pc_sequencer_if #(.PCW(4))  if1 ();

    assign if0.start         = start;
    assign if0.instr_op      = prog[if0.pc[3:0]];
    assign if0.branch_taken  = btk[if0.pc[3:0]];
    assign if0.branch_target = btg[if0.pc[3:0]];
    assign if1.start         = start;
    assign if1.instr_op      = prog[if1.pc];
    assign if1.branch_taken  = btk[if1.pc];
    assign if1.branch_target = btg[if1.pc][3:0];

    pc_sequencer #(.PCW(10), .MEM_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    pc_sequencer #(.PCW(4),  .MEM_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    typedef struct {
        int pc;
        bit fe;
        bit rw;
        bit mw;
        bit busy;
        bit done;
        int ret;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t st0, st1;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rw0_cnt = 0, mw0_cnt = 0, rw1_cnt = 0, mw1_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.pc = 0; e.fe = 0; e.rw = 0; e.mw = 0; e.busy = 0; e.done = 0; e.ret = 0;
        return e;
    endfunction

    // Walks the program an instruction at a time, emitting one expected output
    // vector per clock: FETCH, EXEC, then MEM_LAT wait cycles for loads/stores.
    task automatic gen(input int which);
        exp_t t[$];
        exp_t e;
        exp_t steady;
        int   lat  = (which == 0) ? 1 : 3;
        int   pmax = (which == 0) ? 1024 : 16;
        int   pc   = 0;
        int   ret  = 0;
        int   op;
        bit   halted = 1'b0;
        steady = idle_exp();
        while (!halted && t.size() < 300) begin
            e = idle_exp();
            e.pc = pc; e.ret = ret; e.busy = 1; e.fe = 1;
            t.push_back(e);
            e.fe = 0;
            op = int'(prog[pc % 16]);
            if (op >= 1 && op <= 3) begin
                t.push_back(e);
                pc = btk[pc % 16] ? (int'(btg[pc % 16]) % pmax) : ((pc + 1) % pmax);
            end else if (op == 4 || op == 5) begin
                t.push_back(e);
                for (int i = 1; i <= lat; i++) begin
                    e.rw = (op == 4) && (i == lat);
                    e.mw = (op == 5) && (i == lat);
                    t.push_back(e);
                end
                pc = (pc + 1) % pmax;
            end else if (op == 15) begin
                t.push_back(e);
                halted = 1'b1;
            end else begin
                e.rw = 1;
                t.push_back(e);
                pc = (pc + 1) % pmax;
            end
            if (ret < 65535) ret = ret + 1;
        end
        if (halted) begin
            steady.pc = pc; steady.done = 1; steady.ret = ret;
        end
        if (which == 0) begin
            q0 = t; st0 = steady;
        end else begin
            q1 = t; st1 = steady;
        end
    endtask

    task automatic cmp(input string d, input exp_t e, input int pc, input bit fe,
                       input bit rw, input bit mw, input bit busy, input bit done,
                       input int ret);
        chk({d, ".pc"},        pc,   e.pc);
        chk({d, ".fetch_en"},  fe,   e.fe);
        chk({d, ".reg_wr_en"}, rw,   e.rw);
        chk({d, ".mem_wr_en"}, mw,   e.mw);
        chk({d, ".busy"},      busy, e.busy);
        chk({d, ".done"},      done, e.done);
        chk({d, ".retired"},   ret,  e.ret);
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (chk_en) begin
            if (q0.size() > 0) e = q0.pop_front(); else e = st0;
            cmp("dut0", e, int'(if0.pc), if0.fetch_en, if0.reg_wr_en, if0.mem_wr_en,
                if0.busy, if0.done, int'(if0.retired));
            if (q1.size() > 0) e = q1.pop_front(); else e = st1;
            cmp("dut1", e, int'(if1.pc), if1.fetch_en, if1.reg_wr_en, if1.mem_wr_en,
                if1.busy, if1.done, int'(if1.retired));
            if (if0.reg_wr_en) rw0_cnt++;
            if (if0.mem_wr_en) mw0_cnt++;
            if (if1.reg_wr_en) rw1_cnt++;
            if (if1.mem_wr_en) mw1_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        gen(0);
        gen(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        st0 = idle_exp();
        st1 = idle_exp();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            prog[i] = OP_DONE;
            btk[i]  = 1'b0;
            btg[i]  = '0;
        end
    endtask

    int base_rw, base_mw;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_prog();
        st0 = idle_exp();
        st1 = idle_exp();
        tick(2);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset.pc", int'(if0.pc), 0);
        chk("reset.busy", if0.busy, 0);
        chk("reset.done", if0.done, 0);
        tick(2);

        // ALU, ALU, halt
        prog[0] = OP_SHIFT; prog[1] = 4'b1000; prog[2] = OP_DONE;
        base_rw = rw0_cnt;
        do_start();
        $display("txn: start program ALU,ALU,HALT");
        tick(5);
        chk("prog1.done_early", if0.done, 0);
        tick();
        chk("prog1.done_cycle7", if0.done, 1);
        chk("prog1.pc", int'(if0.pc), 2);
        chk("prog1.retired", int'(if0.retired), 3);
        chk("prog1.reg_wr_pulses", rw0_cnt - base_rw, 2);
        tick(3);

        // Restart from HALT; branch taken at pc 5 to 12, not-taken at 12
        prog[0] = OP_SHIFT; prog[1] = 4'b1000; prog[2] = OP_PUSH; prog[3] = OP_POP;
        prog[4] = 4'b1010;  prog[5] = OP_BEQ;  btk[5] = 1'b1; btg[5] = 10'd12;
        prog[12] = OP_BLT;  btk[12] = 1'b0;    prog[13] = OP_DONE;
        base_rw = rw0_cnt;
        do_start();
        $display("txn: restart from HALT, branch taken pc5->12");
        chk("restart.done_fell", if0.done, 0);
        chk("restart.fetch_en", if0.fetch_en, 1);
        chk("restart.pc", int'(if0.pc), 0);
        tick(12);
        chk("br_taken.pc", int'(if0.pc), 12);
        chk("br_taken.fetch_en", if0.fetch_en, 1);
        chk("br_taken.reg_wr_pulses", rw0_cnt - base_rw, 5);
        tick(4);
        chk("br_taken.halt_pc", int'(if0.pc), 13);
        chk("br_taken.retired", int'(if0.retired), 8);
        tick(2);

        // Same program, branch not taken at pc 5
        btk[5] = 1'b0; prog[6] = OP_DONE;
        do_start();
        $display("txn: branch not taken at pc5");
        tick(12);
        chk("br_not_taken.pc", int'(if0.pc), 6);
        chk("br_not_taken.fetch_en", if0.fetch_en, 1);
        tick(5);

        // Four ALU ops, store, load, halt; start pulse while busy
        clear_prog();
        prog[0] = OP_SHIFT; prog[1] = OP_PUSH; prog[2] = OP_POP; prog[3] = 4'b1001;
        prog[4] = OP_ST;    prog[5] = OP_LD;   prog[6] = OP_DONE;
        base_rw = rw1_cnt;
        base_mw = mw1_cnt;
        do_start();
        $display("txn: store/load program, MEM_LAT=3 on dut1");
        tick(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start.pc", int'(if1.pc), 4);
        chk("busy_start.busy", if1.busy, 1);
        tick(3);
        chk("store.pc_after", int'(if1.pc), 5);
        chk("store.mem_wr_pulses", mw1_cnt - base_mw, 1);
        chk("store.fetch_en", if1.fetch_en, 1);
        tick(7);
        chk("mem.done", if1.done, 1);
        chk("mem.halt_pc", int'(if1.pc), 6);
        chk("mem.retired", int'(if1.retired), 7);
        chk("mem.reg_wr_pulses", rw1_cnt - base_rw, 5);
        tick(2);

        // PC wrap: branch to 14, ALU at 14 and 15; dut1 wraps to 0
        clear_prog();
        prog[0] = OP_BNE; btk[0] = 1'b1; btg[0] = 10'd14;
        prog[14] = OP_SHIFT; prog[15] = OP_PUSH;
        do_start();
        $display("txn: pc wrap past 15");
        tick(6);
        chk("wrap.dut1_pc", int'(if1.pc), 0);
        chk("wrap.dut0_pc", int'(if0.pc), 16);
        tick(4);
        do_reset();
        $display("txn: reset after wrap loop");
        chk("wrap_reset.pc", int'(if1.pc), 0);

        // Reset on 2nd wait cycle of a load aborts it
        clear_prog();
        prog[0] = OP_SHIFT; prog[1] = OP_LD; prog[2] = OP_DONE;
        base_rw = rw1_cnt;
        do_start();
        $display("txn: load aborted by reset");
        tick(5);
        chk("abort.busy", if1.busy, 1);
        do_reset();
        chk("abort.reg_wr_pulses", rw1_cnt - base_rw, 1);
        chk("abort.pc", int'(if1.pc), 0);
        chk("abort.retired", int'(if1.retired), 0);
        chk("abort.busy_after", if1.busy, 0);
        tick(2);

        // Branch to itself: 2-cycle loop
        prog[0] = OP_BEQ; btk[0] = 1'b1; btg[0] = 10'd0;
        do_start();
        $display("txn: branch to self loop");
        tick(8);
        chk("self_loop.pc", int'(if0.pc), 0);
        chk("self_loop.retired", int'(if0.retired), 4);
        do_reset();
        tick(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
